// File: rtl/tdc_block_avg.sv
// Block averager for the DE0 TDC chain: accumulates 2^LOG2_N summed time words
// and presents block mean/min/max through a valid/ready result register.
module tdc_block_avg #(
  parameter int IN_W   = 20,
  parameter int LOG2_N = 6,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_dval,
  input  logic              clear,
  output logic [IN_W-1:0]   out_mean,
  output logic [IN_W-1:0]   out_min,
  output logic [IN_W-1:0]   out_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overrun
);

  localparam int ACC_W = IN_W + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [LOG2_N-1:0] cnt;
  logic [IN_W-1:0]   run_min;
  logic [IN_W-1:0]   run_max;
  logic [IN_W-1:0]   min_sum;
  logic [IN_W-1:0]   max_sum;
  logic              take;
  logic              complete;
  logic              slot_free;
  logic              handshake;

  // Running statistics including the current sample, so the Nth sample lands in its own block.
  always_comb begin
    take      = in_dval && !clear;
    complete  = take && (&cnt);
    handshake = out_valid && out_ready;
    slot_free = !out_valid || out_ready;
    acc_sum   = acc + {{LOG2_N{1'b0}}, in_data};
    min_sum   = (in_data < run_min) ? in_data : run_min;
    max_sum   = (in_data > run_max) ? in_data : run_max;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      cnt     <= '0;
      run_min <= '1;
      run_max <= '0;
    end else if (clear || complete) begin
      acc     <= '0;
      cnt     <= '0;
      run_min <= '1;
      run_max <= '0;
    end else if (take) begin
      acc     <= acc_sum;
      cnt     <= cnt + CNT_ONE;
      run_min <= min_sum;
      run_max <= max_sum;
    end
  end

  // A completed block either refills the slot or, when the slot is still owned, is counted as lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_mean  <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
      overrun   <= 1'b0;
    end else if (complete) begin
      if (slot_free) begin
        out_mean  <= acc_sum[ACC_W-1:LOG2_N];
        out_min   <= min_sum;
        out_max   <= max_sum;
        out_valid <= 1'b1;
      end else begin
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + DROP_ONE;
        end
        overrun <= 1'b1;
      end
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_block_avg.sv
// Self-checking bench for tdc_block_avg (LOG2_N=2): a block-level model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_tdc_block_avg;

  localparam int IN_W   = 20;
  localparam int LOG2_N = 2;
  localparam int DROP_W = 16;
  localparam int N      = 1 << LOG2_N;

  logic              clk = 1'b0;
  logic              rst;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_dval = 1'b0;
  logic              clear = 1'b0;
  logic              out_ready = 1'b1;
  logic [IN_W-1:0]   out_mean;
  logic [IN_W-1:0]   out_min;
  logic [IN_W-1:0]   out_max;
  logic              out_valid;
  logic [DROP_W-1:0] drop_cnt;
  logic              overrun;

  int pass_count = 0;
  int check_count = 0;

  int          samples[$];
  logic        model_valid = 1'b0;
  longint      model_mean = 0;
  longint      model_min = 0;
  longint      model_max = 0;
  longint      model_drop = 0;
  logic        model_over = 1'b0;

  tdc_block_avg #(.IN_W(IN_W), .LOG2_N(LOG2_N), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dval(in_dval), .clear(clear),
    .out_mean(out_mean), .out_min(out_min), .out_max(out_max), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
  endtask

  // Inputs change 1ns after a rising edge and are captured on the following one.
  task automatic applyStimulus(input logic [IN_W-1:0] d, input logic v, input logic c);
    @(posedge clk);
    #1;
    in_data = d;
    in_dval = v;
    clear   = c;
  endtask

  task automatic idle();
    applyStimulus(20'h3C3C3, 1'b0, 1'b0);
  endtask

  // Block-level model: collect samples, reduce a full block with plain arithmetic.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        samples.delete();
        model_valid = 1'b0;
        model_mean = 0; model_min = 0; model_max = 0;
        model_drop = 0; model_over = 1'b0;
      end else begin
        automatic logic done = 1'b0;
        automatic logic hs = model_valid && out_ready;
        automatic longint sum = 0, mn = 0, mx = 0;
        if (clear) samples.delete();
        else if (in_dval) begin
          samples.push_back(int'(in_data));
          if (samples.size() == N) begin
            mn = samples[0]; mx = samples[0];
            foreach (samples[i]) begin
              sum += samples[i];
              if (samples[i] < mn) mn = samples[i];
              if (samples[i] > mx) mx = samples[i];
            end
            samples.delete();
            done = 1'b1;
          end
        end
        if (done) begin
          if (!model_valid || out_ready) begin
            model_mean = sum / N; model_min = mn; model_max = mx;
            model_valid = 1'b1;
          end else begin
            if (model_drop < (64'd1 << DROP_W) - 1) model_drop++;
            model_over = 1'b1;
          end
        end else if (hs) begin
          model_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cmp_valid", 32'(out_valid), 32'(model_valid));
      checkOutput("cmp_mean", 32'(out_mean), 32'(model_mean));
      checkOutput("cmp_min", 32'(out_min), 32'(model_min));
      checkOutput("cmp_max", 32'(out_max), 32'(model_max));
      checkOutput("cmp_drop", 32'(drop_cnt), 32'(model_drop));
      checkOutput("cmp_overrun", 32'(overrun), 32'(model_over));
    end
  end

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mean", 32'(out_mean), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    #9 rst = 1'b1;

    // Basic block with consumer always ready.
    out_ready = 1'b1;
    applyStimulus(20'd100, 1, 0);
    applyStimulus(20'd200, 1, 0);
    applyStimulus(20'd300, 1, 0);
    applyStimulus(20'd400, 1, 0);
    idle();
    checkOutput("basic_valid", 32'(out_valid), 32'd1);
    checkOutput("basic_mean", 32'(out_mean), 32'd250);
    checkOutput("basic_min", 32'(out_min), 32'd100);
    checkOutput("basic_max", 32'(out_max), 32'd400);
    idle();
    checkOutput("basic_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("basic_mean_hold", 32'(out_mean), 32'd250);

    // Truncating mean and full-scale samples.
    applyStimulus(20'd1, 1, 0);
    applyStimulus(20'd2, 1, 0);
    applyStimulus(20'd2, 1, 0);
    applyStimulus(20'd2, 1, 0);
    idle();
    checkOutput("floor_mean", 32'(out_mean), 32'd1);
    checkOutput("floor_max", 32'(out_max), 32'd2);
    for (int i = 0; i < 4; i++) applyStimulus(20'hFFFFF, 1, 0);
    idle();
    checkOutput("full_mean", 32'(out_mean), 32'hFFFFF);
    checkOutput("full_min", 32'(out_min), 32'hFFFFF);

    // Back-to-back blocks 10..17.
    for (int i = 10; i < 14; i++) applyStimulus(20'(i), 1, 0);
    applyStimulus(20'd14, 1, 0);
    checkOutput("b2b_mean0", 32'(out_mean), 32'd11);
    checkOutput("b2b_min0", 32'(out_min), 32'd10);
    checkOutput("b2b_max0", 32'(out_max), 32'd13);
    for (int i = 15; i < 18; i++) applyStimulus(20'(i), 1, 0);
    idle();
    checkOutput("b2b_valid1", 32'(out_valid), 32'd1);
    checkOutput("b2b_mean1", 32'(out_mean), 32'd15);
    checkOutput("b2b_min1", 32'(out_min), 32'd14);
    checkOutput("b2b_max1", 32'(out_max), 32'd17);
    idle();

    // Completion coinciding with a handshake refills the slot without a drop.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(20'd20, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(20'd30, 1, 0);
    checkOutput("sim_held", 32'(out_mean), 32'd20);
    applyStimulus(20'd30, 1, 0);
    out_ready = 1'b1;
    idle();
    checkOutput("sim_valid", 32'(out_valid), 32'd1);
    checkOutput("sim_mean", 32'(out_mean), 32'd30);
    checkOutput("sim_drop", 32'(drop_cnt), 32'd0);
    idle();

    // Back-pressure: 12 samples, two blocks lost.
    out_ready = 1'b0;
    for (int i = 40; i < 52; i++) applyStimulus(20'(i), 1, 0);
    idle();
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_mean", 32'(out_mean), 32'd41);
    checkOutput("bp_min", 32'(out_min), 32'd40);
    checkOutput("bp_max", 32'(out_max), 32'd43);
    checkOutput("bp_drop", 32'(drop_cnt), 32'd2);
    checkOutput("bp_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    idle();
    checkOutput("bp_release", 32'(out_valid), 32'd0);
    checkOutput("bp_drop_kept", 32'(drop_cnt), 32'd2);

    // clear with a coincident sample discards it and restarts the block.
    applyStimulus(20'd7, 1, 0);
    applyStimulus(20'd8, 1, 0);
    applyStimulus(20'd99, 1, 1);
    applyStimulus(20'd5, 1, 0);
    applyStimulus(20'd5, 1, 0);
    applyStimulus(20'd5, 1, 0);
    checkOutput("clr_nofire", 32'(out_valid), 32'd0);
    applyStimulus(20'd9, 1, 0);
    idle();
    checkOutput("clr_mean", 32'(out_mean), 32'd6);
    checkOutput("clr_min", 32'(out_min), 32'd5);
    checkOutput("clr_max", 32'(out_max), 32'd9);
    checkOutput("clr_overrun", 32'(overrun), 32'd1);

    // Reset mid-block drops the partial block and all outputs.
    applyStimulus(20'd1000, 1, 0);
    applyStimulus(20'd2000, 1, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_mean", 32'(out_mean), 32'd0);
    checkOutput("mid_rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun), 32'd0);
    in_dval = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(20'd4, 1, 0);
    applyStimulus(20'd4, 1, 0);
    applyStimulus(20'd4, 1, 0);
    checkOutput("post_rst_nofire", 32'(out_valid), 32'd0);
    applyStimulus(20'd8, 1, 0);
    idle();
    checkOutput("post_rst_mean", 32'(out_mean), 32'd5);
    checkOutput("post_rst_min", 32'(out_min), 32'd4);
    checkOutput("post_rst_max", 32'(out_max), 32'd8);
    idle();
    idle();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
